// File: rtl/phy_serial_rx_s2p.sv
// Serial-to-parallel receive lane: COM hunt, lock, byte delivery.
// Feeds the lane demux with one byte and a valid strobe per byte period.
module phy_serial_rx_s2p #(
  parameter logic [7:0] COM     = 8'hBC,
  parameter int         BC_LOCK = 4
) (
  input  logic       clk_16f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam logic [3:0] LOCK_N = 4'(BC_LOCK);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [3:0] bc_inc;
  logic [7:0] data_d;
  logic       valid_d;
  logic       active_d;
  logic [7:0] window;
  logic       byte_done;
  logic       is_com;

  assign window    = {shift_q[6:0], data_in};
  assign byte_done = (bit_cnt_q == 3'd7);
  assign is_com    = (window == COM);
  assign bc_inc    = bc_cnt_q + 4'd1;

  // Next state: alignment hunt, lock counting and byte capture.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_out;
    valid_d   = valid_out;
    active_d  = active;
    unique case (state_q)
      SEARCH: begin
        if (is_com) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          if (BC_LOCK == 1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (byte_done) begin
          if (is_com) begin
            bc_cnt_d = bc_inc;
            if (bc_inc == LOCK_N) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            bc_cnt_d = 4'd0;
            state_d  = SEARCH;
          end
        end
      end
      ACTIVE: begin
        if (byte_done) begin
          if (is_com) begin
            valid_d = 1'b0;
          end else begin
            data_d  = window;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // Registers; synchronous reset wins over everything.
  always_ff @(posedge clk_16f) begin
    if (!reset_L) begin
      state_q   <= SEARCH;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= window;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_out  <= data_d;
      valid_out <= valid_d;
      active    <= active_d;
    end
  end

endmodule

// File: tb/tb_phy_serial_rx_s2p.sv
// Directed bench for phy_serial_rx_s2p, queue-based expectations.
// Second instance covers the single-COM lock build.
module tb_phy_serial_rx_s2p;

  logic       clk_16f = 1'b0;
  logic       reset_L = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] d0, d1;
  logic       v0, v1, a0, a1;

  phy_serial_rx_s2p #(.BC_LOCK(4)) u_dut (
    .clk_16f  (clk_16f),
    .reset_L  (reset_L),
    .data_in  (data_in),
    .data_out (d0),
    .valid_out(v0),
    .active   (a0)
  );

  phy_serial_rx_s2p #(.BC_LOCK(1)) u_dut1 (
    .clk_16f  (clk_16f),
    .reset_L  (reset_L),
    .data_in  (data_in),
    .data_out (d1),
    .valid_out(v1),
    .active   (a1)
  );

  always #5 clk_16f = ~clk_16f;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic       a;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   errs   = 0;
  int   checks = 0;
  bit   sel    = 1'b0;

  function automatic exp_t obs();
    exp_t o;
    o = sel ? {d1, v1, a1} : {d0, v0, a0};
    return o;
  endfunction

  task automatic check(input string tag, input exp_t o, input exp_t e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%h/%b/%b expected=%h/%b/%b",
             tag, o.d, o.v, o.a, e.d, e.v, e.a);
    end
  endtask

  task automatic send_bit(input logic b, input string tag);
    data_in = b;
    @(posedge clk_16f);
    #1;
    check(tag, obs(), cur);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] ed,
                           input logic ev, input logic ea,
                           input string tag);
    exp_t e;
    e = '{ed, ev, ea};
    sb.push_back(e);
    for (int i = 7; i >= 0; i--) begin
      data_in = b[i];
      @(posedge clk_16f);
      #1;
      if (i != 0) begin
        check({tag, "_hold"}, obs(), cur);
      end else begin
        e = sb.pop_front();
        check(tag, obs(), e);
        cur = e;
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset_L = 1'b0;
    cur     = '0;
    for (int i = 0; i < n; i++) begin
      data_in = 1'($urandom);
      @(posedge clk_16f);
      #1;
      check("reset", obs(), cur);
    end
    reset_L = 1'b1;
  endtask

  initial begin
    cur = '0;
    #2;

    // 1: reset, then idle zeros
    do_reset(3);
    for (int i = 0; i < 24; i++) send_bit(1'b0, "idle");

    // 2: offset alignment
    send_bit(1'b1, "junk");
    send_bit(1'b0, "junk");
    send_bit(1'b1, "junk");
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0, "t2_bc1");
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0, "t2_bc2");
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0, "t2_bc3");
    send_byte(8'hBC, 8'h00, 1'b0, 1'b1, "t2_bc4");
    send_byte(8'hA5, 8'hA5, 1'b1, 1'b1, "t2_a5");
    send_byte(8'h3C, 8'h3C, 1'b1, 1'b1, "t2_3c");

    // 3: broken lock then relock
    do_reset(2);
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0, "t3_bc1");
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0, "t3_bc2");
    send_byte(8'h00, 8'h00, 1'b0, 1'b0, "t3_brk");
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0, "t3_re1");
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0, "t3_re2");
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0, "t3_re3");
    send_byte(8'hBC, 8'h00, 1'b0, 1'b1, "t3_re4");
    send_byte(8'h55, 8'h55, 1'b1, 1'b1, "t3_55");

    // 4: COM while active
    send_byte(8'h11, 8'h11, 1'b1, 1'b1, "t4_11");
    send_byte(8'hBC, 8'h11, 1'b0, 1'b1, "t4_com");
    send_byte(8'h22, 8'h22, 1'b1, 1'b1, "t4_22");

    // 5: reset in the middle of payload 0x9A
    send_bit(1'b1, "t5_b1");
    send_bit(1'b0, "t5_b2");
    send_bit(1'b0, "t5_b3");
    reset_L = 1'b0;
    data_in = 1'b1;
    @(posedge clk_16f);
    #1;
    cur = '0;
    check("t5_mid_reset", obs(), cur);
    reset_L = 1'b1;
    send_bit(1'b1, "t5_tail");
    send_bit(1'b0, "t5_tail");
    send_bit(1'b1, "t5_tail");
    send_bit(1'b0, "t5_tail");
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0, "t5_bc1");
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0, "t5_bc2");
    send_byte(8'hBC, 8'h00, 1'b0, 1'b0, "t5_bc3");
    send_byte(8'hBC, 8'h00, 1'b0, 1'b1, "t5_bc4");
    send_byte(8'h66, 8'h66, 1'b1, 1'b1, "t5_66");

    // 6: single-COM lock instance
    do_reset(2);
    sel = 1'b1;
    send_byte(8'hBC, 8'h00, 1'b0, 1'b1, "t6_bc");
    send_byte(8'h7E, 8'h7E, 1'b1, 1'b1, "t6_7e");
    send_byte(8'hBC, 8'h7E, 1'b0, 1'b1, "t6_com");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
